// File: rtl/wb_decompressor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_decompressor_pkg : CW link protocol constants, header layout and decode |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package wb_decompressor_pkg;

  localparam int RW        = 16;
  localparam int WB_ADDR_W = 24;

  localparam logic [3:0] CW_CYC_SINGLE = 4'b0000;
  localparam logic [3:0] CW_CYC_B8     = 4'b0001;
  localparam logic [3:0] CW_CYC_B4     = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADR   = 3'd1,
    S_HACK  = 3'd2,
    S_WB    = 3'd3,
    S_XACK  = 3'd4,
    S_WNEXT = 3'd5
  } state_t;

  // Field order mirrors the header word bit positions, MSB first.
  typedef struct packed {
    logic [7:0] adr_hi;
    logic [3:0] cyc_type;
    logic       we;
    logic [1:0] sel;
    logic       valid;
  } cw_hdr_t;

  function automatic cw_hdr_t cw_hdr_decode(input logic [RW-1:0] word);
    return cw_hdr_t'(word);
  endfunction

  function automatic logic [2:0] cw_burst_end(input logic [3:0] cyc_type);
    case (cyc_type)
      CW_CYC_B8:     return 3'd7;
      CW_CYC_B4:     return 3'd3;
      CW_CYC_SINGLE: return 3'd0;
      default:       return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_decompressor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_decompressor : far end of the CW link, replays transfers on Wishbone    |
// | Optional slave-response timeout enabled by defining CW_TIMEOUT_EN.        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_decompressor
  import wb_decompressor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RW-1:0]        cw_io_i,
  output logic [RW-1:0]        cw_io_o,
  output logic                 cw_io_oe,
  input  logic                 cw_req,
  input  logic                 cw_dir,
  output logic                 cw_ack,
  output logic                 cw_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic [WB_ADDR_W-1:0] wb_adr,
  output logic [RW-1:0]        wb_o_dat,
  output logic                 wb_we,
  output logic [1:0]           wb_sel,
  input  logic [RW-1:0]        wb_i_dat,
  input  logic                 wb_ack,
  input  logic                 wb_err
);

  state_t               r_state;
  logic [WB_ADDR_W-1:0] r_base;
  logic [2:0]           r_cnt;
  logic [2:0]           r_end;

  cw_hdr_t    w_hdr;
  logic [2:0] w_next_cnt;
  logic       w_tmo;
  logic       w_wb_done;
  logic       w_report_err;
  logic       w_unused_dir;

  assign w_hdr        = cw_hdr_decode(cw_io_i);
  assign w_next_cnt   = r_cnt + 3'd1;
  assign w_unused_dir = cw_dir;

`ifdef CW_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Any cycle outside S_WB clears the count, so every entry starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != S_WB)) r_tmo <= '0;
    else                            r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo = (r_state == S_WB) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
`endif

  assign w_wb_done    = wb_ack | wb_err | w_tmo;
  // A simultaneous ack and err reports err; a timeout is an err word.
  assign w_report_err = wb_err | (w_tmo & ~wb_ack);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_cnt    <= '0;
      r_end    <= '0;
      cw_io_o  <= '0;
      cw_io_oe <= 1'b0;
      cw_ack   <= 1'b0;
      cw_err   <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_adr   <= '0;
      wb_o_dat <= '0;
      wb_we    <= 1'b0;
      wb_sel   <= '0;
    end else begin
      cw_ack <= 1'b0;
      cw_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cw_req && w_hdr.valid) begin
            r_base[WB_ADDR_W-1:RW] <= w_hdr.adr_hi;
            r_end                  <= cw_burst_end(w_hdr.cyc_type);
            r_cnt                  <= '0;
            wb_we                  <= w_hdr.we;
            wb_sel                 <= w_hdr.sel;
            r_state                <= S_ADR;
          end
        end
        S_ADR: begin
          r_base[RW-1:0] <= cw_io_i;
          cw_ack         <= 1'b1;
          r_state        <= S_HACK;
        end
        S_HACK: begin
          if (wb_we) wb_o_dat <= cw_io_i;
          else       cw_io_oe <= 1'b1;
          wb_cyc  <= 1'b1;
          wb_stb  <= 1'b1;
          wb_adr  <= r_base;
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_wb_done) begin
            wb_stb <= 1'b0;
            if (!wb_we) cw_io_o <= wb_i_dat;
            if (w_report_err) cw_err <= 1'b1;
            else              cw_ack <= 1'b1;
            r_state <= S_XACK;
          end
        end
        S_XACK: begin
          if (r_cnt == r_end) begin
            wb_cyc   <= 1'b0;
            cw_io_oe <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= w_next_cnt;
            if (wb_we) begin
              r_state <= S_WNEXT;
            end else begin
              wb_stb  <= 1'b1;
              wb_adr  <= r_base + WB_ADDR_W'(w_next_cnt);
              r_state <= S_WB;
            end
          end
        end
        S_WNEXT: begin
          if (cw_req) begin
            wb_o_dat <= cw_io_i;
            wb_stb   <= 1'b1;
            wb_adr   <= r_base + WB_ADDR_W'(r_cnt);
            r_state  <= S_WB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_decompressor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_decompressor : directed vector bench for wb_decompressor            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_wb_decompressor;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] cw_io_i = '0;
  logic [15:0] cw_io_o;
  logic        cw_io_oe;
  logic        cw_req = 1'b0;
  logic        cw_dir = 1'b0;
  logic        cw_ack;
  logic        cw_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [15:0] wb_i_dat = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  wb_decompressor #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .cw_io_i(cw_io_i), .cw_io_o(cw_io_o), .cw_io_oe(cw_io_oe),
    .cw_req(cw_req), .cw_dir(cw_dir), .cw_ack(cw_ack), .cw_err(cw_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_o_dat(wb_o_dat),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_i_dat(wb_i_dat),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] adr;
    int          n;
    int          err_idx;
    logic [23:0] exp_base;
    logic        exp_we;
    logic [1:0]  exp_sel;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Zero-wait slave model plus link pulse monitor.
  int          sl_idx   = 0;
  int          sl_limit = 0;
  int          err_idx  = -1;
  logic [15:0] rd_data [8];
  logic [15:0] wdat    [8];
  logic [23:0] log_adr [8];
  logic [15:0] log_dat [8];
  logic        log_we  [8];
  logic [1:0]  log_sel [8];
  int          mon_acks = 0;
  int          mon_both = 0;

  always @(negedge i_clk) begin
    if (wb_stb && (sl_idx < sl_limit)) begin
      wb_ack          = (sl_idx != err_idx);
      wb_err          = (sl_idx == err_idx);
      wb_i_dat        = rd_data[sl_idx];
      log_adr[sl_idx] = wb_adr;
      log_dat[sl_idx] = wb_o_dat;
      log_we[sl_idx]  = wb_we;
      log_sel[sl_idx] = wb_sel;
      sl_idx          = sl_idx + 1;
    end else begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end
    if (cw_ack) mon_acks = mon_acks + 1;
    if (cw_ack && cw_err) mon_both = mon_both + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit noise);
    int pulses, acks, errs, cyc_low, budget, exp_err;
    pulses = 0; acks = 0; errs = 0; cyc_low = 0; budget = 300;
    exp_err  = (v.err_idx >= 0 && v.err_idx < v.n) ? 1 : 0;
    sl_idx   = 0;
    sl_limit = v.n;
    err_idx  = v.err_idx;
    for (int k = 0; k < 8; k++) begin
      rd_data[k] = 16'hBEEF ^ 16'(k << 8);
      wdat[k]    = 16'h00A0 + 16'(k);
    end
    @(posedge i_clk); #1; cw_req = 1'b1; cw_io_i = v.hdr;
    @(posedge i_clk); #1; cw_req = 1'b0; cw_io_i = v.adr;
    @(posedge i_clk); #1;
    check("hdr_ack", {31'd0, cw_ack}, 1);
    cw_io_i = wdat[0];
    @(posedge i_clk); #1;
    check("stb_latency", {31'd0, wb_stb}, 1);
    check("oe_dir", {31'd0, cw_io_oe}, {31'd0, ~v.exp_we});
    if (noise) begin cw_req = 1'b1; cw_io_i = 16'h5501; end
    while (pulses < v.n && budget > 0) begin
      if (!wb_cyc) cyc_low++;
      if (cw_ack || cw_err) begin
        if (cw_ack) begin
          acks++;
          if (!v.exp_we) check("rd_word", {16'd0, cw_io_o}, {16'd0, rd_data[pulses]});
        end else begin
          errs++;
        end
        pulses++;
        if (v.exp_we && pulses < v.n) begin
          @(posedge i_clk); #1; cw_req = 1'b1; cw_io_i = wdat[pulses];
        end
      end
      @(posedge i_clk); #1; cw_req = 1'b0; budget--;
    end
    check("words_done", pulses, v.n);
    check("ack_count", acks, v.n - exp_err);
    check("err_count", errs, exp_err);
    check("cyc_held", cyc_low, 0);
    check("end_cyc", {31'd0, wb_cyc}, 0);
    check("end_oe", {31'd0, cw_io_oe}, 0);
    check("wb_words", sl_idx, v.n);
    for (int k = 0; k < v.n && k < 8; k++) begin
      check("wb_adr", {8'd0, log_adr[k]}, {8'd0, v.exp_base + 24'(k)});
      check("wb_we", {31'd0, log_we[k]}, {31'd0, v.exp_we});
      check("wb_sel", {30'd0, log_sel[k]}, {30'd0, v.exp_sel});
      if (v.exp_we) check("wb_dat", {16'd0, log_dat[k]}, {16'd0, 16'h00A0 + 16'(k)});
    end
  endtask

  vec_t vecs [6];
  int   acks0, bad, budget, cnt;

  initial begin
    vecs[0] = '{16'h1201, 16'h3456, 1, -1, 24'h123456, 1'b0, 2'b00};
    vecs[1] = '{16'h002F, 16'hFFFE, 4, -1, 24'h00FFFE, 1'b1, 2'b11};
    vecs[2] = '{16'hAB13, 16'h0100, 8,  2, 24'hAB0100, 1'b0, 2'b01};
    vecs[3] = '{16'hFF1D, 16'hFFFC, 8, -1, 24'hFFFFFC, 1'b1, 2'b10};
    vecs[4] = '{16'h05F3, 16'h0007, 1, -1, 24'h050007, 1'b0, 2'b01};
    vecs[5] = '{16'h3421, 16'h0010, 4,  3, 24'h340010, 1'b0, 2'b00};

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_cyc", {31'd0, wb_cyc}, 0);
    check("rst_stb", {31'd0, wb_stb}, 0);
    check("rst_adr", {8'd0, wb_adr}, 0);
    check("rst_wdat", {16'd0, wb_o_dat}, 0);
    check("rst_we_sel", {29'd0, wb_we, wb_sel}, 0);
    check("rst_ack_err", {30'd0, cw_ack, cw_err}, 0);
    check("rst_cwo", {15'd0, cw_io_o, cw_io_oe}, 0);
    i_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i == 2);

    // Header with valid bit clear must be ignored.
    acks0 = mon_acks; bad = 0;
    @(posedge i_clk); #1; cw_req = 1'b1; cw_io_i = 16'h1200;
    @(posedge i_clk); #1; cw_req = 1'b0;
    repeat (5) begin @(posedge i_clk); #1; if (wb_cyc || wb_stb) bad++; end
    check("nohdr_wb", bad, 0);
    check("nohdr_ack", mon_acks - acks0, 0);

    // Reset while word 1 of an 8-burst read is outstanding.
    sl_idx = 0; sl_limit = 1; err_idx = -1;
    @(posedge i_clk); #1; cw_req = 1'b1; cw_io_i = 16'hAB11;
    @(posedge i_clk); #1; cw_req = 1'b0; cw_io_i = 16'h0000;
    budget = 20;
    while (!(wb_stb && sl_idx == 1) && budget > 0) begin @(posedge i_clk); #1; budget--; end
    check("rst_reach_word1", {31'd0, budget > 0}, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("midrst_cyc", {30'd0, wb_cyc, wb_stb}, 0);
    i_rst = 1'b0;
    acks0 = mon_acks;
    repeat (4) @(posedge i_clk);
    #1;
    check("midrst_noack", mon_acks - acks0, 0);
    check("midrst_idle", {31'd0, wb_cyc}, 0);
    run_txn(vecs[0], 1'b0);

`ifdef CW_TIMEOUT_EN
    sl_idx = 0; sl_limit = 0; err_idx = -1;
    @(posedge i_clk); #1; cw_req = 1'b1; cw_io_i = 16'h1201;
    @(posedge i_clk); #1; cw_req = 1'b0; cw_io_i = 16'h3456;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("tmo_stb", {31'd0, wb_stb}, 1);
    cnt = 0;
    while (!cw_err && cnt < 20) begin @(posedge i_clk); #1; cnt++; end
    check("tmo_latency", cnt, 4);
    @(posedge i_clk); #1;
    check("tmo_idle", {31'd0, wb_cyc}, 0);
`endif

    check("ack_err_exclusive", mon_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
